// File: rtl/weight_quant_packer.sv
// ---------------------------------------------------------------------------
// weight_quant_packer
//
// Quantizes a stream of signed Q16.16 weight samples to signed int8 and packs
// four of them into one 32-bit word. A run produces NUM_WORDS words and ends
// with a one-cycle done pulse.
//
// Quantization per accepted sample:
//   P = din * SCALE_INV        (64-bit signed product, Q32.32)
//   Q = (P + 2^31) >>> 32      (round half up)
//   Q saturated to [-128, 127]
// Lane k (k = 0..3, in acceptance order) lands in dout[31-8k : 24-8k].
//
// Parameters
//   WIDTH_INPUT : din_i width, signed Q16.16 (at most 63)
//   SCALE_INV   : reciprocal of the weight scale, unsigned Q16.16
//   NUM_WORDS   : packed words per run
//
// Ports
//   clk_i    in   clock, all state changes on the rising edge
//   rstn_i   in   synchronous active-low reset
//   start_i  in   begins a run when idle
//   din_i    in   signed Q16.16 weight sample
//   valid_i  in   din_i valid
//   ready_o  out  block accepts din_i (registered)
//   dout_o   out  four packed int8 weights, lane 0 in the MSB byte
//   valid_o  out  dout_o valid (registered)
//   ready_i  in   consumer accepts dout_o
//   done_o   out  one-cycle run-complete pulse (registered)
// ---------------------------------------------------------------------------
module weight_quant_packer #(
  parameter int          WIDTH_INPUT = 32,
  parameter logic [31:0] SCALE_INV   = 32'h0080_0000,
  parameter int          NUM_WORDS   = 8
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   start_i,
  input  logic [WIDTH_INPUT-1:0] din_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [31:0]            dout_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   done_o
);

  localparam int WORD_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    OUTPUT  = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [1:0]        lane_q;
  logic [WORD_W-1:0] word_q;
  logic [31:0]       pack_q;
  logic [31:0]       dout_q;
  logic              ready_q;
  logic              valid_q;
  logic              done_q;

  logic              accept;
  logic              handshake;
  logic              last_lane;
  logic              last_word;

  // ready_q mirrors state COLLECT and valid_q mirrors OUTPUT, so qualifying
  // with the registered flags is the same as qualifying with the state.
  assign accept    = valid_i & ready_q;
  assign handshake = valid_q & ready_i;
  assign last_lane = (lane_q == 2'd3);
  assign last_word = (word_q == LAST_WORD);

  // -------------------------------------------------------------------------
  // Quantizer
  // -------------------------------------------------------------------------
  logic signed [63:0] din_ext;
  logic signed [63:0] scale_ext;
  logic signed [63:0] prod;
  logic signed [63:0] rnd;
  logic signed [63:0] q64;
  logic        [7:0]  q8;

  always_comb begin
    din_ext   = 64'($signed(din_i));
    scale_ext = $signed({32'd0, SCALE_INV});
    prod      = din_ext * scale_ext;
    rnd       = prod + 64'sh0000_0000_8000_0000;
    q64       = rnd >>> 32;
    if (q64 > 64'sd127) begin
      q8 = 8'h7F;
    end else if (q64 < -64'sd128) begin
      q8 = 8'h80;
    end else begin
      q8 = q64[7:0];
    end
  end

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (accept && last_lane) begin
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        if (handshake) begin
          state_d = last_word ? DONE : COLLECT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status flags are registered from the next state, so each one is high for
  // exactly the cycles the FSM sits in the matching state and never depends
  // combinationally on valid_i or ready_i.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ready_q <= (state_d == COLLECT);
      valid_q <= (state_d == OUTPUT);
      done_q  <= (state_d == DONE);
    end
  end

  // -------------------------------------------------------------------------
  // Lane/word counters and packing
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      lane_q <= '0;
      word_q <= '0;
      pack_q <= '0;
      dout_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            lane_q <= '0;
            word_q <= '0;
            pack_q <= '0;
          end
        end
        COLLECT: begin
          if (accept) begin
            case (lane_q)
              2'd0:    pack_q[31:24] <= q8;
              2'd1:    pack_q[23:16] <= q8;
              2'd2:    pack_q[15:8]  <= q8;
              default: pack_q[7:0]   <= q8;
            endcase
            lane_q <= lane_q + 2'd1;
            // The fourth lane goes straight into the output word so that
            // dout_o is complete in the first OUTPUT cycle.
            if (last_lane) begin
              dout_q <= {pack_q[31:8], q8};
            end
          end
        end
        OUTPUT: begin
          if (handshake) begin
            word_q <= word_q + 1'b1;
            lane_q <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign done_o  = done_q;
  assign dout_o  = dout_q;

endmodule

// File: tb/tb_weight_quant_packer.sv
// ---------------------------------------------------------------------------
// tb_weight_quant_packer
//
// Directed bench for weight_quant_packer. Samples are quantized by a
// real-arithmetic reference and packed into expected words; a compare process
// checks the DUT outputs on every falling edge against that queue and
// against handshake/run counts. Literal expectations pin known words.
// ---------------------------------------------------------------------------
module tb_weight_quant_packer;

  localparam int          NW    = 8;
  localparam logic [31:0] SCALE = 32'h0080_0000;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        start_i;
  logic [31:0] din_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] dout_o;
  logic        valid_o;
  logic        ready_i;
  logic        done_o;

  always #5 clk = ~clk;

  weight_quant_packer #(
    .WIDTH_INPUT (32),
    .SCALE_INV   (SCALE),
    .NUM_WORDS   (NW)
  ) dut (
    .clk_i   (clk),
    .rstn_i  (rstn_i),
    .start_i (start_i),
    .din_i   (din_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .dout_o  (dout_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .done_o  (done_o)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  int          lane_n      = 0;
  logic [31:0] acc         = '0;
  int          hs_total    = 0;
  int          hs_cnt      = 0;
  int          done_count  = 0;
  bit          prev_rst    = 1'b1;
  bit          done_exp    = 1'b0;

  logic [31:0] edge_tbl [8] = '{32'h0000FF00, 32'h0000FE00, 32'hFFFEFF00,
                                32'hFFFF0100, 32'h00000000, 32'hFFFFFFFF,
                                32'h00000180, 32'hFFFFFE80};

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference quantizer: real value of sample times real scale, rounded half
  // up, clamped to int8.
  function automatic logic [7:0] quant(input logic [31:0] d);
    real x;
    real r;
    int  qi;
    logic [31:0] qv;
    x = (real'($signed(d)) / 65536.0) * (real'(SCALE) / 65536.0);
    r = $floor(x + 0.5);
    if (r > 127.0) return 8'h7F;
    if (r < -128.0) return 8'h80;
    qi = int'(r);
    qv = qi;
    return qv[7:0];
  endfunction

  task automatic push_lane(input logic [31:0] d);
    acc = acc | ({24'd0, quant(d)} << (8 * (3 - lane_n)));
    lane_n++;
    if (lane_n == 4) begin
      exp_q.push_back(acc);
      acc    = '0;
      lane_n = 0;
    end
  endtask

  function automatic logic [31:0] get_sample();
    logic signed [31:0] t;
    if ($urandom_range(0, 2) == 0) return edge_tbl[$urandom_range(0, 7)];
    t = $urandom;
    return t >>> $urandom_range(12, 22);
  endfunction

  // ---------------------------------------------------------------------------
  // Compare process
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (prev_rst) begin
      chk("rst_ready_o", {31'd0, ready_o}, 32'd0);
      chk("rst_valid_o", {31'd0, valid_o}, 32'd0);
      chk("rst_done_o",  {31'd0, done_o},  32'd0);
      chk("rst_dout_o",  dout_o, 32'd0);
      exp_q.delete();
      hs_cnt   = 0;
      done_exp = 1'b0;
    end else begin
      chk("done_o", {31'd0, done_o}, {31'd0, done_exp});
      chk("valid_o", {31'd0, valid_o}, {31'd0, exp_q.size() != 0});
      if (valid_o && exp_q.size() != 0) chk("dout_o", dout_o, exp_q[0]);
      if (valid_o || done_o) chk("ready_o_busy", {31'd0, ready_o}, 32'd0);
      if (done_o) done_count++;
      done_exp = 1'b0;
      if (rstn_i && valid_o && ready_i) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        hs_total++;
        hs_cnt++;
        if (hs_cnt == NW) begin
          hs_cnt   = 0;
          done_exp = 1'b1;
        end
      end
    end
    prev_rst = !rstn_i;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (each starts and ends just after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sample(input logic [31:0] d, output int waits);
    bit got = 1'b0;
    din_i   = d;
    valid_i = 1'b1;
    waits   = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready_o === 1'b1) begin
        got = 1'b1;
        break;
      end
      waits++;
      tick();
    end
    if (got) begin
      tick();
      valid_i = 1'b0;
      push_lane(d);
    end else begin
      valid_i = 1'b0;
      chk("accept_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic send(input logic [31:0] d);
    int w;
    send_sample(d, w);
  endtask

  task automatic send_lanes(input int n);
    for (int i = 0; i < n; i++) begin
      send(get_sample());
      if (i < n - 1) repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic start_run();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Waits for the done pulse, pokes start_i during it, and checks that the
  // block drops back to idle rather than starting again.
  task automatic finish_run();
    bit got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done_o === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk("done_timeout", 32'd0, 32'd1);
      tick();
    end else begin
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      @(negedge clk);
      chk("start_in_done_ready", {31'd0, ready_o}, 32'd0);
      chk("done_single_cycle", {31'd0, done_o}, 32'd0);
      tick();
      @(negedge clk);
      chk("idle_after_done", {31'd0, ready_o}, 32'd0);
      tick();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] x;
    logic [31:0] hold;
    int          w;

    rstn_i  = 1'b0;
    start_i = 1'b0;
    valid_i = 1'b0;
    din_i   = '0;
    ready_i = 1'b1;
    repeat (3) tick();
    rstn_i = 1'b1;

    // valid_i in IDLE must not be consumed
    valid_i = 1'b1;
    din_i   = 32'h12345678;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ready", {31'd0, ready_o}, 32'd0);
      tick();
    end
    valid_i = 1'b0;

    // ---- run 1 ----
    start_run();
    send(32'h00008000);
    send(32'hFFFF8000);
    send(32'h00000100);
    send(32'hFFFFFF00);
    @(negedge clk);
    chk("basic_valid_latency", {31'd0, valid_o}, 32'd1);
    chk("basic_dout", dout_o, 32'h40C00100);
    tick();

    // saturation word, with start_i pulsed mid-collection
    send(32'h00010000);
    send(32'hFFFF0000);
    start_i = 1'b1;
    @(negedge clk);
    chk("start_in_collect_ready", {31'd0, ready_o}, 32'd1);
    tick();
    start_i = 1'b0;
    send(32'h7FFFFFFF);
    send(32'h80000000);
    @(negedge clk);
    chk("sat_dout", dout_o, 32'h7F807F80);
    tick();

    // backpressure on word 2 with a sample waiting on valid_i
    ready_i = 1'b0;
    send_lanes(4);
    x       = get_sample();
    din_i   = x;
    valid_i = 1'b1;
    @(negedge clk);
    hold = dout_o;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_ready_low", {31'd0, ready_o}, 32'd0);
      chk("bp_valid_high", {31'd0, valid_o}, 32'd1);
      chk("bp_dout_stable", dout_o, hold);
      tick();
    end
    ready_i = 1'b1;
    send_sample(x, w);
    chk("bp_resume_latency", w, 32'd1);
    send_lanes(3);
    repeat (4) send_lanes(4);
    finish_run();

    // ---- run 2: reset after two samples of word 3 ----
    start_run();
    repeat (3) send_lanes(4);
    send_lanes(2);
    rstn_i  = 1'b0;
    lane_n  = 0;
    acc     = '0;
    valid_i = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("midrst_ready", {31'd0, ready_o}, 32'd0);
    chk("midrst_valid", {31'd0, valid_o}, 32'd0);
    chk("midrst_done",  {31'd0, done_o},  32'd0);
    chk("midrst_dout",  dout_o, 32'd0);
    tick();
    rstn_i = 1'b1;
    tick();

    // ---- run 3: fresh run after reset ----
    start_run();
    send(32'h00008000);
    send(32'hFFFF8000);
    send(32'h00000100);
    send(32'hFFFFFF00);
    @(negedge clk);
    chk("fresh_word0_dout", dout_o, 32'h40C00100);
    tick();
    repeat (7) send_lanes(4);
    finish_run();

    repeat (3) tick();
    chk("handshake_total", hs_total, 32'd19);
    chk("done_pulses", done_count, 32'd2);
    chk("expected_queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    miscompares++;
    $display("FAIL watchdog: got timeout, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
